number_formatter: RTL and testbench
===================================

Name: number_formatter

Overview:
- Downstream stage of the radix atoi converter; it consumes each converted result (number/valid/error) and re-serialises it.
- Output is an ASCII digit stream in the same sop/eop framed format the converter accepts: first word = radix, then digit characters MSB-first, eop on the last digit.
- Closes the loop, so a converter plus this block must round-trip any frame bit-exactly.
- Iterative: one divide-by-RADIX per cycle, digits held in a small buffer, one-entry holding register on the input.

Parameters:
- INPUT_WIDTH, 64, width of in_number (matches converter OUTPUT_WIDTH).
- OUTPUT_WIDTH, 16, width of out_data words (matches converter INPUT_WIDTH).
- RADIX, 10, output base, legal 2..16.
- MAX_DIGITS, 20, digit buffer depth; must be at least the digit count of 2^INPUT_WIDTH-1 in RADIX.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_number  in  INPUT_WIDTH  unsigned result from converter.
- in_valid  in  1  one-cycle pulse qualifying in_number/in_error.
- in_error  in  1  when high with in_valid, the result is an error.
- out_data  out  OUTPUT_WIDTH  radix word or ASCII code, zero-extended.
- out_valid  out  1  out_data qualifier.
- out_sop  out  1  first word of frame (radix word).
- out_eop  out  1  last word of frame.
- busy  out  1  FSM not in IDLE or holding register full.
- overflow  out  1  one-cycle pulse: input dropped.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM=IDLE, holding register empty, digit count 0.
- Input acceptance:
  - in_valid in IDLE with holding register empty: captured directly.
  - in_valid while busy with holding register empty: stored in the holding register.
  - in_valid with holding register full: dropped and overflow pulses the next cycle.
- in_valid&&in_error results are discarded (see Optional Feature); in_error without in_valid is ignored.
- FSM states:
  - IDLE -> DIV: on an accepted non-error item (direct or from the holding register).
  - DIV: each cycle q<=q/RADIX; remainder pushed into the digit buffer; count++. Exit to HDR when the new q==0. Value 0 gives a single digit '0'.
  - HDR: one cycle. out_valid=1, out_sop=1, out_data=RADIX.
  - DIG: one digit per cycle, read from count-1 down to 0. ASCII = 48+d for d<10, 65+d-10 otherwise. out_eop=1 on index 0. Then go to IDLE, or straight to DIV if the holding register is full.
- Timing:
  - Outputs are registered; frames are gap-free.
  - Accept to sop = N+1 cycles, where N = digit count. Frame length = N+1 words.
  - Minimum inter-frame gap: 1 idle cycle when nothing is pending.
- Simultaneous in_valid and the eop cycle: the input goes to the holding register if empty, else overflow.
- Reset mid-frame: output ends immediately with no eop; the holding register and buffer are cleared.
- out_sop and out_eop are never high in the same cycle.

Optional Feature:
- NUMBER_FORMATTER_ERROR_FRAME_EN defined: an error result produces a 2-word frame, RADIX (sop) then 63 '?' (eop), queued like a normal item.
- Undefined: error results are silently dropped and do not occupy the holding register.

Decomposition:
- Shared package atoi_pkg:
  - ASCII_ZERO=48, ASCII_A=65, ASCII_ERR=63.
  - FSM state encodings IDLE/DIV/HDR/DIG.
  - digit-count width function clog2(MAX_DIGITS+1).
- One natural sub-module: radix_divider. Combinational q/RADIX giving quotient and remainder, instantiated once in the DIV datapath.

Test Plan:
- in_number=163, RADIX=10 -> frame 10(sop),49,54,51(eop); sop 4 cycles after accept.
- in_number=0 -> frame 10(sop),48(eop); in_number=2^64-1 -> 21-word frame "18446744073709551615".
- RADIX=16, in_number=0xAF -> 16(sop),65,70(eop).
- Pulses of 163, then 7 one cycle later, then 9 one cycle after that, all during DIV -> frames for 163 and 7 back-to-back; 9 dropped, overflow pulses once.
- in_valid with in_error=1 -> no frame without the macro; frame 10(sop),63(eop) with it.
- rst low during DIG of 163 -> outputs 0 at once, no eop; a new in_valid of 5 after release -> 10(sop),53(eop).

Source files
------------

// File: rtl/atoi_pkg.sv
// Shared types and constants for the radix atoi converter / number formatter pair.
package atoi_pkg;
  localparam int ASCII_ZERO = 48;
  localparam int ASCII_A    = 65;
  localparam int ASCII_ERR  = 63;

  typedef enum logic [1:0] {IDLE, DIV, HDR, DIG} fmt_state_t;

  function automatic int cnt_w(input int max_digits);
    return $clog2(max_digits + 1);
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d < 4'd10) ? 8'(ASCII_ZERO) + {4'b0, d} : 8'(ASCII_A - 10) + {4'b0, d};
  endfunction
endpackage

// File: rtl/number_formatter_if.sv
// Result-in / framed-digit-stream-out bundle; slave is the formatter's view.
interface number_formatter_if #(
  parameter int INPUT_WIDTH  = 64,
  parameter int OUTPUT_WIDTH = 16
) ();
  logic [INPUT_WIDTH-1:0]  in_number;
  logic                    in_valid;
  logic                    in_error;
  logic [OUTPUT_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_sop;
  logic                    out_eop;
  logic                    busy;
  logic                    overflow;

  modport master (output in_number, in_valid, in_error,
                  input  out_data, out_valid, out_sop, out_eop, busy, overflow);
  modport slave  (input  in_number, in_valid, in_error,
                  output out_data, out_valid, out_sop, out_eop, busy, overflow);
endinterface

// File: rtl/radix_divider.sv
// Combinational divide by a constant radix: quotient plus low-order digit.
module radix_divider #(
  parameter int W     = 64,
  parameter int RADIX = 10
) (
  input  logic [W-1:0] num,
  output logic [W-1:0] quo,
  output logic [3:0]   rem
);
  localparam logic [W-1:0] R = W'(RADIX);

  assign quo = num / R;
  assign rem = 4'(num % R);
endmodule

// File: rtl/number_formatter.sv
// Re-serialises converter results as sop/eop framed ASCII digit streams.
// Optional: NUMBER_FORMATTER_ERROR_FRAME_EN turns error results into RADIX,'?' frames.
module number_formatter
  import atoi_pkg::*;
#(
  parameter int INPUT_WIDTH  = 64,
  parameter int OUTPUT_WIDTH = 16,
  parameter int RADIX        = 10,
  parameter int MAX_DIGITS   = 20
) (
  input logic clk,
  input logic rst,
  number_formatter_if.slave bus
);
  localparam int CW = cnt_w(MAX_DIGITS);
`ifdef NUMBER_FORMATTER_ERROR_FRAME_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  fmt_state_t state, state_d;
  logic [INPUT_WIDTH-1:0] q, q_d, quo, hold_num, hold_num_d, ld_num;
  logic [3:0] rem;
  logic [3:0] dbuf [MAX_DIGITS];
  logic [CW-1:0] cnt, cnt_d, idx, idx_d;
  logic errf, errf_d, hold_vld, hold_d, hold_err, hold_err_d;
  logic take, direct, ld, ld_err, wr_en, ovf_d;
  logic [OUTPUT_WIDTH-1:0] data_d;

  radix_divider #(.W(INPUT_WIDTH), .RADIX(RADIX)) u_div (.num(q), .quo(quo), .rem(rem));

  assign take   = bus.in_valid && (!bus.in_error || ERR_EN);
  assign direct = (state == IDLE) && !hold_vld;
  assign bus.busy = (state != IDLE) || hold_vld;

  always_comb begin
    state_d = state;  q_d = q;  cnt_d = cnt;  idx_d = idx;  errf_d = errf;
    hold_d = hold_vld;  hold_num_d = hold_num;  hold_err_d = hold_err;
    ld = 1'b0;  ld_num = bus.in_number;  ld_err = bus.in_error;
    wr_en = 1'b0;  ovf_d = 1'b0;
    case (state)
      IDLE: begin
        if (hold_vld) begin
          ld = 1'b1;  ld_num = hold_num;  ld_err = hold_err;  hold_d = 1'b0;
        end else if (take) begin
          ld = 1'b1;
        end
      end
      DIV: begin
        wr_en = 1'b1;
        q_d   = quo;
        cnt_d = cnt + 1'b1;
        if (quo == '0) state_d = HDR;
      end
      HDR: begin
        state_d = DIG;
        idx_d   = cnt - 1'b1;
      end
      DIG: begin
        if (idx == '0) begin
          // a pending item starts dividing straight after eop
          if (hold_vld) begin
            ld = 1'b1;  ld_num = hold_num;  ld_err = hold_err;  hold_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      q_d     = ld_num;
      errf_d  = ld_err;
      cnt_d   = ld_err ? CW'(1) : '0;
      state_d = ld_err ? HDR : DIV;
    end
    if (take && !direct) begin
      if (!hold_vld) begin
        hold_d = 1'b1;  hold_num_d = bus.in_number;  hold_err_d = bus.in_error;
      end else begin
        ovf_d = 1'b1;
      end
    end
    // outputs are registered against the state being entered
    if (state_d == HDR)  data_d = OUTPUT_WIDTH'(RADIX);
    else if (errf_d)     data_d = OUTPUT_WIDTH'(ASCII_ERR);
    else                 data_d = OUTPUT_WIDTH'(digit_ascii(dbuf[idx_d]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;  q <= '0;  cnt <= '0;  idx <= '0;  errf <= 1'b0;
      hold_vld <= 1'b0;  hold_num <= '0;  hold_err <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) dbuf[i] <= '0;
      bus.out_data <= '0;  bus.out_valid <= 1'b0;
      bus.out_sop <= 1'b0;  bus.out_eop <= 1'b0;  bus.overflow <= 1'b0;
    end else begin
      state <= state_d;  q <= q_d;  cnt <= cnt_d;  idx <= idx_d;  errf <= errf_d;
      hold_vld <= hold_d;  hold_num <= hold_num_d;  hold_err <= hold_err_d;
      if (wr_en) dbuf[cnt] <= rem;
      bus.out_data  <= data_d;
      bus.out_valid <= (state_d == HDR) || (state_d == DIG);
      bus.out_sop   <= (state_d == HDR);
      bus.out_eop   <= (state_d == DIG) && (idx_d == '0);
      bus.overflow  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_number_formatter.sv
// Scoreboard bench: radix-10 and radix-16 formatters share one input stream.
module tb_number_formatter;
  typedef struct {
    logic [15:0] data;
    bit          sop;
    bit          eop;
    int          sop_cyc;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [63:0] in_number = '0;
  logic in_valid = 1'b0, in_error = 1'b0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int ovf_cnt [2] = '{0, 0};
  int rdx [2] = '{10, 16};
  exp_t sb [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  number_formatter_if #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(16)) b10 ();
  number_formatter_if #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(16)) b16 ();
  assign b10.in_number = in_number;  assign b10.in_valid = in_valid;  assign b10.in_error = in_error;
  assign b16.in_number = in_number;  assign b16.in_valid = in_valid;  assign b16.in_error = in_error;

  number_formatter #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(16), .RADIX(10), .MAX_DIGITS(20))
    dut10 (.clk(clk), .rst(rst), .bus(b10.slave));
  number_formatter #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(16), .RADIX(16), .MAX_DIGITS(20))
    dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  logic [15:0] od [2];
  logic ovl [2], osop [2], oeop [2], obusy [2], oovf [2];
  assign od[0] = b10.out_data;  assign ovl[0] = b10.out_valid;  assign osop[0] = b10.out_sop;
  assign oeop[0] = b10.out_eop;  assign obusy[0] = b10.busy;  assign oovf[0] = b10.overflow;
  assign od[1] = b16.out_data;  assign ovl[1] = b16.out_valid;  assign osop[1] = b16.out_sop;
  assign oeop[1] = b16.out_eop;  assign obusy[1] = b16.busy;  assign oovf[1] = b16.overflow;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  // reference frame built from repeated division, independent of the DUT
  task automatic push_frame(input logic [63:0] n, input bit err, input bit timed);
    for (int i = 0; i < 2; i++) begin
      int unsigned dg [$];
      logic [63:0] v = n;
      exp_t e;
      if (err) begin
        dg.push_back(999);
      end else begin
        do begin
          dg.push_front(int'(v % 64'(rdx[i])));
          v = v / 64'(rdx[i]);
        end while (v != 0);
      end
      e.data = 16'(rdx[i]);  e.sop = 1'b1;  e.eop = 1'b0;
      e.sop_cyc = (timed && !err) ? cyc + dg.size() + 1 : -1;
      sb[i].push_back(e);
      for (int j = 0; j < dg.size(); j++) begin
        if (err)             e.data = 16'd63;
        else if (dg[j] < 10) e.data = 16'(48 + dg[j]);
        else                 e.data = 16'(55 + dg[j]);
        e.sop = 1'b0;  e.eop = (j == dg.size() - 1);  e.sop_cyc = -1;
        sb[i].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (oovf[i]) ovf_cnt[i]++;
        if (osop[i] && oeop[i]) chk("sop_eop_same_cycle", 1, 0);
        if (ovl[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("unexpected_word_r%0d", rdx[i]), 0, 1);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            chk($sformatf("data_r%0d", rdx[i]), od[i], e.data);
            chk($sformatf("sop_r%0d", rdx[i]), osop[i], e.sop);
            chk($sformatf("eop_r%0d", rdx[i]), oeop[i], e.eop);
            if (e.sop_cyc >= 0) chk($sformatf("sop_latency_r%0d", rdx[i]), cyc, e.sop_cyc);
          end
        end
      end
    end
  end

  task automatic send(input logic [63:0] n, input bit err, input bit exp_frame, input bit timed);
    @(negedge clk);
    in_number = n;  in_error = err;  in_valid = 1'b1;
    if (exp_frame) push_frame(n, err, timed);
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0;  in_error = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    @(posedge clk); #1;
    while (k < 400 && (sb[0].size() != 0 || sb[1].size() != 0 ||
                       obusy[0] || obusy[1] || ovl[0] || ovl[1])) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_left_r10"}, sb[0].size(), 0);
    chk({tag, "_left_r16"}, sb[1].size(), 0);
  endtask

  initial begin
    int o0, o1, k;
    bit err_en;
`ifdef NUMBER_FORMATTER_ERROR_FRAME_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_data", od[0], 0);     chk("rst_valid", ovl[0], 0);
    chk("rst_sop", osop[0], 0);    chk("rst_eop", oeop[0], 0);
    chk("rst_busy", obusy[0], 0);  chk("rst_ovf", oovf[0], 0);
    chk("rst_valid16", ovl[1], 0); chk("rst_busy16", obusy[1], 0);
    rst = 1'b1;

    send(64'd163, 0, 1, 1);  release_in();  drain("f163");
    send(64'd0, 0, 1, 1);    release_in();  drain("fzero");
    send('1, 0, 1, 1);       release_in();  drain("fmax");
    send(64'hAF, 0, 1, 1);   release_in();  drain("fAF");

    o0 = ovf_cnt[0];  o1 = ovf_cnt[1];
    send(64'd163, 0, 1, 1);
    send(64'd7, 0, 1, 0);
    send(64'd9, 0, 0, 0);
    release_in();  drain("fovf");
    chk("ovf_pulses_r10", ovf_cnt[0] - o0, 1);
    chk("ovf_pulses_r16", ovf_cnt[1] - o1, 1);

    send(64'd123, 1, err_en, 0);  release_in();
    #1 chk("err_busy", obusy[0], err_en);
    drain("ferr");

    send(64'd163, 0, 1, 1);  release_in();
    k = 0;
    while (k < 50 && !(ovl[0] && !osop[0])) begin
      @(negedge clk);
      k++;
    end
    chk("reach_dig", k < 50, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", ovl[0], 0);  chk("midrst_eop", oeop[0], 0);
    chk("midrst_data", od[0], 0);    chk("midrst_busy", obusy[0], 0);
    sb[0].delete();  sb[1].delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(64'd5, 0, 1, 1);  release_in();  drain("fpost");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
